// File: rtl/reaction_timer_core.sv
// -----------------------------------------------------------------------------
// reaction_timer_core
//
// Purpose:
//    Reaction-timer engine running on the board clock. It derives its own
//    timing tick, waits a pseudo-random preparation delay, then counts ticks
//    in packed BCD until the player presses stop. Early presses are flagged as
//    cheats, a full counter saturates into a timeout, and the fastest valid
//    result is kept as the best time.
//
// Ports:
//    clk         board clock
//    reset       synchronous, active-high
//    start       debounced button level, acts on its rising edge
//    stop        debounced button level, acts on its rising edge
//    led         status pattern for the LED bank
//    digits      current/last result, packed BCD, digit 0 in [3:0]
//    best        best result, packed BCD (all nines until a result exists)
//    best_valid  best holds a real result
//    state       FSM state code (IDLE=0 .. TIMEOUT=5)
//    done        one-cycle pulse on entry to DONE
//    tick        one-cycle tick strobe
// -----------------------------------------------------------------------------
module reaction_timer_core #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int TICK_HZ     = 1000,
   parameter int DIGITS      = 4,
   parameter int PREP_MIN    = 1000,
   parameter int PREP_RAND_W = 10,
   parameter int LED_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   output logic [LED_W-1:0]      led,
   output logic [4*DIGITS-1:0]   digits,
   output logic [4*DIGITS-1:0]   best,
   output logic                  best_valid,
   output logic [2:0]            state,
   output logic                  done,
   output logic                  tick
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int DIV_W = $clog2(DIV);
   localparam int PC_W  = $clog2(PREP_MIN + 2**PREP_RAND_W);

   localparam logic [4*DIGITS-1:0] ALL_NINE  = {DIGITS{4'h9}};
   localparam logic [LED_W-1:0]    LED_LOWER = {{(LED_W/2){1'b0}}, {(LED_W/2){1'b1}}};
   localparam logic [LED_W-1:0]    LED_UPPER = {{(LED_W/2){1'b1}}, {(LED_W/2){1'b0}}};
   localparam logic [LED_W-1:0]    LED_ALT   = {(LED_W/2){2'b10}};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PREP    = 3'd1,
      TIMING  = 3'd2,
      DONE    = 3'd3,
      CHEAT   = 3'd4,
      TIMEOUT = 3'd5
   } stateT;

   stateT               r_state;
   stateT               w_nextState;
   logic                r_startQ;
   logic                r_stopQ;
   logic [15:0]         r_lfsr;
   logic [DIV_W-1:0]    r_divCnt;
   logic                r_tick;
   logic [PC_W-1:0]     r_prepCnt;
   logic [4*DIGITS-1:0] r_digits;
   logic [4*DIGITS-1:0] r_best;
   logic                r_bestValid;
   logic [LED_W-1:0]    r_led;
   logic                r_done;

   logic                w_startEdge;
   logic                w_stopEdge;
   logic                w_lfsrFb;
   logic [DIV_W-1:0]    w_divNext;
   logic [PC_W-1:0]     w_prepLoad;
   logic                w_allNine;
   logic                w_enterPrep;
   logic                w_enterTiming;
   logic                w_enterDone;
   logic [LED_W-1:0]    w_ledNext;

   // Ripple a +1 through the BCD digits, least significant digit first.
   // Once a digit absorbs the carry the remaining digits are untouched.
   function automatic logic [4*DIGITS-1:0] bcdInc(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] res;
      logic                carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               res[4*i +: 4] = 4'd0;
            end else begin
               res[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   assign w_startEdge = start & ~r_startQ;
   assign w_stopEdge  = stop & ~r_stopQ;
   assign w_lfsrFb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_prepLoad  = PC_W'(PREP_MIN) + PC_W'(r_lfsr[PREP_RAND_W-1:0]);
   assign w_allNine   = (r_digits == ALL_NINE);

   assign w_enterPrep   = (w_nextState == PREP)   && (r_state != PREP);
   assign w_enterTiming = (w_nextState == TIMING) && (r_state != TIMING);
   assign w_enterDone   = (w_nextState == DONE)   && (r_state != DONE);

   // The divider restarts whenever a timed phase begins so that the first
   // tick of PREP or TIMING always lands exactly DIV cycles after entry.
   always_comb begin
      w_divNext = r_divCnt + DIV_W'(1);
      if (w_enterPrep || w_enterTiming || (r_divCnt == DIV_W'(DIV - 1))) begin
         w_divNext = '0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Stop is checked first in PREP/TIMING so it wins a
   // simultaneous start+stop; the other states only ever look at start.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_startEdge) w_nextState = PREP;
         end
         PREP: begin
            if (w_stopEdge) begin
               w_nextState = CHEAT;
            end else if (r_tick && (r_prepCnt == PC_W'(1))) begin
               w_nextState = TIMING;
            end
         end
         TIMING: begin
            if (w_stopEdge) begin
               w_nextState = DONE;
            end else if (r_tick && w_allNine) begin
               w_nextState = TIMEOUT;
            end
         end
         DONE, CHEAT, TIMEOUT: begin
            if (w_startEdge) w_nextState = PREP;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Output decode works on the upcoming state so the registered LED pattern
   // changes on the same edge as the state itself.
   always_comb begin
      w_ledNext = '0;
      case (w_nextState)
         TIMING:  w_ledNext = '1;
         DONE:    w_ledNext = LED_LOWER;
         CHEAT:   w_ledNext = LED_ALT;
         TIMEOUT: w_ledNext = LED_UPPER;
         default: w_ledNext = '0;
      endcase
   end

   // Datapath: edge-detect history, LFSR, tick divider, preparation countdown,
   // BCD result counter and the best-time register. The result counter only
   // advances when the FSM stays in TIMING, so a tick that coincides with the
   // stop press or with the saturating all-nines value is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_startQ    <= 1'b0;
         r_stopQ     <= 1'b0;
         r_lfsr      <= 16'hACE1;
         r_divCnt    <= '0;
         r_tick      <= 1'b0;
         r_prepCnt   <= '0;
         r_digits    <= '0;
         r_best      <= ALL_NINE;
         r_bestValid <= 1'b0;
         r_led       <= '0;
         r_done      <= 1'b0;
      end else begin
         r_startQ <= start;
         r_stopQ  <= stop;
         r_lfsr   <= {r_lfsr[14:0], w_lfsrFb};
         r_divCnt <= w_divNext;
         r_tick   <= (w_divNext == DIV_W'(DIV - 1));
         r_led    <= w_ledNext;
         r_done   <= w_enterDone;

         if (w_enterPrep) begin
            r_prepCnt <= w_prepLoad;
         end else if ((r_state == PREP) && r_tick) begin
            r_prepCnt <= r_prepCnt - PC_W'(1);
         end

         if (w_enterTiming) begin
            r_digits <= '0;
         end else if ((r_state == TIMING) && (w_nextState == TIMING) && r_tick) begin
            r_digits <= bcdInc(r_digits);
         end

         if (w_enterDone && (!r_bestValid || (r_digits < r_best))) begin
            r_best      <= r_digits;
            r_bestValid <= 1'b1;
         end
      end
   end

   assign led        = r_led;
   assign digits     = r_digits;
   assign best       = r_best;
   assign best_valid = r_bestValid;
   assign state      = r_state;
   assign done       = r_done;
   assign tick       = r_tick;

endmodule

// File: tb/tb_reaction_timer_core.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer_core
//
// Purpose:
//    Self-checking bench for reaction_timer_core with DIV=10, PREP_MIN=5 and
//    PREP_RAND_W=4. A table of timed runs exercises the result counter and the
//    best-time register; hand-written sequences cover cheating, simultaneous
//    button edges, reset mid-run and timeout saturation. The timeout is shown
//    on a second, two-digit instance so the saturation point is reachable in
//    about a thousand cycles.
// -----------------------------------------------------------------------------
module tb_reaction_timer_core;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;

   logic [15:0] led;
   logic [15:0] digits;
   logic [15:0] best;
   logic        best_valid;
   logic [2:0]  state;
   logic        done;
   logic        tick;

   logic [15:0] tLed;
   logic [7:0]  tDigits;
   logic [7:0]  tBest;
   logic        tBestValid;
   logic [2:0]  tState;
   logic        tDone;
   logic        tTick;

   logic [15:0] mLfsr;

   int checks;
   int errors;

   typedef struct {
      int          stopDelay;
      logic [15:0] expDigits;
      logic [15:0] expBest;
   } runVecT;

   runVecT runs[4];

   reaction_timer_core #(
      .CLK_HZ(1000), .TICK_HZ(100), .DIGITS(4),
      .PREP_MIN(5), .PREP_RAND_W(4), .LED_W(16)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .led(led), .digits(digits), .best(best), .best_valid(best_valid),
      .state(state), .done(done), .tick(tick)
   );

   reaction_timer_core #(
      .CLK_HZ(1000), .TICK_HZ(100), .DIGITS(2),
      .PREP_MIN(5), .PREP_RAND_W(4), .LED_W(16)
   ) u_dutT (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .led(tLed), .digits(tDigits), .best(tBest), .best_valid(tBestValid),
      .state(tState), .done(tDone), .tick(tTick)
   );

   // 10 ns board clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
   // Sampling it just before a start edge gives the delay the DUT will load.
   always @(posedge clk) begin
      if (reset) mLfsr <= 16'hACE1;
      else       mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one-cycle button levels that the next edge samples, then release.
   task automatic applyStimulus(input logic startV, input logic stopV);
      start = startV;
      stop  = stopV;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic waitState(input bit useT, input logic [2:0] target, input int bound,
                            output int cycles);
      bit found;
      found  = 1'b0;
      cycles = -1;
      for (int i = 1; i <= bound; i++) begin
         if (!found) begin
            @(posedge clk);
            #1;
            if ((useT ? tState : state) == target) begin
               found  = 1'b1;
               cycles = i;
            end
         end
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_state"},     32'(state),      32'd0);
      checkOutput({tag, "_digits"},    32'(digits),     32'h0);
      checkOutput({tag, "_best"},      32'(best),       32'h9999);
      checkOutput({tag, "_bestValid"}, 32'(best_valid), 32'd0);
      checkOutput({tag, "_done"},      32'(done),       32'd0);
      checkOutput({tag, "_led"},       32'(led),        32'h0);
      checkOutput({tag, "_tick"},      32'(tick),       32'd0);
   endtask

   // Start a run and confirm the preparation delay matches the reference LFSR.
   task automatic startRun(input string tag);
      logic [3:0] rnd;
      int         cyc;
      rnd = mLfsr[3:0];
      applyStimulus(1'b1, 1'b0);
      checkOutput({tag, "_prepState"}, 32'(state), 32'd1);
      waitState(1'b0, 3'd2, 400, cyc);
      checkOutput({tag, "_prepCycles"}, 32'(cyc), 32'((5 + int'(rnd)) * 10));
      checkOutput({tag, "_timingLed"}, 32'(led), 32'hFFFF);
   endtask

   initial begin
      int cyc;

      checks = 0;
      errors = 0;
      runs[0] = '{stopDelay: 237, expDigits: 16'h0023, expBest: 16'h0023};
      runs[1] = '{stopDelay: 500, expDigits: 16'h0050, expBest: 16'h0023};
      runs[2] = '{stopDelay: 120, expDigits: 16'h0012, expBest: 16'h0012};
      runs[3] = '{stopDelay: 299, expDigits: 16'h0029, expBest: 16'h0012};

      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      step(2);
      reset = 1'b0;
      checkResetValues("reset");

      // Stop in IDLE does nothing.
      applyStimulus(1'b0, 1'b1);
      checkOutput("idleStop_state", 32'(state), 32'd0);

      // Table of timed runs: stop is raised stopDelay cycles after TIMING
      // entry and sampled on the following edge.
      for (int r = 0; r < 4; r++) begin
         startRun($sformatf("run%0d", r));
         step(runs[r].stopDelay);
         applyStimulus(1'b0, 1'b1);
         checkOutput($sformatf("run%0d_state", r),     32'(state),      32'd3);
         checkOutput($sformatf("run%0d_digits", r),    32'(digits),     32'(runs[r].expDigits));
         checkOutput($sformatf("run%0d_done", r),      32'(done),       32'd1);
         checkOutput($sformatf("run%0d_led", r),       32'(led),        32'h00FF);
         checkOutput($sformatf("run%0d_best", r),      32'(best),       32'(runs[r].expBest));
         checkOutput($sformatf("run%0d_bestValid", r), 32'(best_valid), 32'd1);
         step(1);
         checkOutput($sformatf("run%0d_doneLow", r),   32'(done),       32'd0);
         applyStimulus(1'b0, 1'b1);
         checkOutput($sformatf("run%0d_doneStop", r),  32'(state),      32'd3);
      end

      // Cheat: stop during PREP keeps the previous digits.
      applyStimulus(1'b1, 1'b0);
      checkOutput("cheat_prep", 32'(state), 32'd1);
      step(15);
      applyStimulus(1'b0, 1'b1);
      checkOutput("cheat_state",  32'(state),  32'd4);
      checkOutput("cheat_led",    32'(led),    32'hAAAA);
      checkOutput("cheat_digits", 32'(digits), 32'h0029);
      step(1);

      // Restart from CHEAT, check the tick strobe, then press both buttons
      // in TIMING: stop wins and five ticks have been counted.
      startRun("restart");
      step(9);
      checkOutput("tick_high",   32'(tick),   32'd1);
      checkOutput("tick_digits", 32'(digits), 32'h0000);
      step(1);
      checkOutput("tick_low",    32'(tick),   32'd0);
      checkOutput("tick_first",  32'(digits), 32'h0001);
      step(45);
      applyStimulus(1'b1, 1'b1);
      checkOutput("both_timing_state",  32'(state),  32'd3);
      checkOutput("both_timing_digits", 32'(digits), 32'h0005);
      checkOutput("both_timing_best",   32'(best),   32'h0005);
      step(1);

      // Both in DONE: start wins. Both in PREP: stop wins.
      applyStimulus(1'b1, 1'b1);
      checkOutput("both_done_state", 32'(state), 32'd1);
      step(3);
      applyStimulus(1'b1, 1'b1);
      checkOutput("both_prep_state", 32'(state), 32'd4);
      step(1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("cheat_restart", 32'(state), 32'd1);

      // Reset mid-PREP clears everything, including the best time.
      step(5);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checkResetValues("midReset");

      // Timeout on the two-digit instance: 99 ticks reach 99, the next tick
      // saturates into TIMEOUT and the digits stay put afterwards.
      applyStimulus(1'b1, 1'b0);
      waitState(1'b1, 3'd2, 400, cyc);
      checkOutput("to_entered", 32'(cyc > 0), 32'd1);
      step(990);
      checkOutput("to_digits99",  32'(tDigits), 32'h99);
      checkOutput("to_stillTime", 32'(tState),  32'd2);
      step(10);
      checkOutput("to_state",  32'(tState),  32'd5);
      checkOutput("to_led",    32'(tLed),    32'hFF00);
      checkOutput("to_digits", 32'(tDigits), 32'h99);
      step(30);
      checkOutput("to_hold",      32'(tDigits), 32'h99);
      checkOutput("to_holdState", 32'(tState),  32'd5);
      applyStimulus(1'b0, 1'b1);
      checkOutput("to_stopIgnored", 32'(tState), 32'd5);
      step(1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("to_restart", 32'(tState), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
